// File: rtl/fibo_gen_param.sv
// fibo_gen_param: flow-controlled Fibonacci source with programmable seeds and
// term count, presented over a valid/ready stream.
// Optional build macro FIBO_SAT_EN: when defined, every term from the first
// overflowing one onward is all-ones. When undefined, terms wrap modulo 2^WIDTH.
// In both builds the sticky overflow flag reports the first wrapped term.
// Timing: a start accepted at edge k loads the seeds at that edge. The stream
// then spends one cycle priming, so the first term is valid after edge k+1.
// A zero-length run therefore pulses done after edge k+1 as well.

module fibo_gen_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6,
  parameter int SEED0 = 0,
  parameter int SEED1 = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] fibo_series,
  output logic [CNT_W-1:0] term_idx,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] L_SEED0 = WIDTH'(SEED0);
  localparam logic [WIDTH-1:0] L_SEED1 = WIDTH'(SEED1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_cur;
  logic [WIDTH-1:0] r_nxt;
  logic             r_cur_tag;
  logic             r_nxt_tag;
  logic [CNT_W-1:0] r_n_terms;
  logic [CNT_W-1:0] r_idx;
  logic             r_out_valid;
  logic             r_overflow;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH:0]   w_sum;
  logic             w_wrap;
  logic [WIDTH-1:0] w_nxt_val;
  logic             w_fire;
  logic             w_last;

  // Next-term adder. The wrap tag spreads from any term that was already
  // tagged, so a wrap propagates into every later term.
  assign w_sum  = {1'b0, r_cur} + {1'b0, r_nxt};
  assign w_wrap = w_sum[WIDTH] | r_cur_tag | r_nxt_tag;
`ifdef FIBO_SAT_EN
  assign w_nxt_val = w_wrap ? '1 : w_sum[WIDTH-1:0];
`else
  assign w_nxt_val = w_sum[WIDTH-1:0];
`endif

  assign w_fire = r_out_valid & out_ready;
  assign w_last = (r_idx == (r_n_terms - CNT_W'(1)));

  // Control FSM and datapath. Every output comes straight from a register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: state is updated with non-blocking assignments only. Every
      // register then sees the values from before the edge, whatever the
      // statement order is.
      r_state     <= S_IDLE;
      r_cur       <= L_SEED0;
      r_nxt       <= L_SEED1;
      r_cur_tag   <= 1'b0;
      r_nxt_tag   <= 1'b0;
      r_n_terms   <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n_terms  <= n_terms;
            r_cur      <= L_SEED0;
            r_nxt      <= L_SEED1;
            r_cur_tag  <= 1'b0;
            r_nxt_tag  <= 1'b0;
            r_idx      <= '0;
            r_overflow <= 1'b0;
            if (n_terms != '0) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
            end
          end
        end

        S_RUN: begin
          if (!r_out_valid) begin
            // Priming cycle: the seeds are loaded, so expose term 0 now.
            r_out_valid <= 1'b1;
          end else if (w_fire) begin
            if (w_last) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_cur      <= r_nxt;
              r_nxt      <= w_nxt_val;
              r_cur_tag  <= r_nxt_tag;
              r_nxt_tag  <= w_wrap;
              r_overflow <= r_overflow | r_nxt_tag;
              r_idx      <= r_idx + CNT_W'(1);
            end
          end
        end

        S_DONE: begin
          if (r_done) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            // A zero-length run arrives here straight from IDLE. Its pulse
            // waits one cycle so it lines up with the priming latency.
            r_done <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign fibo_series = r_cur;
  assign term_idx    = r_idx;
  assign overflow    = r_overflow;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_fibo_gen_param.sv
// tb_fibo_gen_param: randomized bench for fibo_gen_param. Two instances share
// the same stimulus: one uses seeds 0/1 and the other uses seeds 5/7. Each
// output is compared against a sequence model built from plain arithmetic.
// Expected values follow the FIBO_SAT_EN build macro.

module tb_fibo_gen_param;

  localparam int WIDTH = 8;
  localparam int CNT_W = 6;
  localparam int MOD   = 1 << WIDTH;

  typedef struct packed {
    logic [31:0] val;
    logic        ovf;
  } term_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] n_terms;
  logic             out_ready;

  logic             a_out_valid, b_out_valid;
  logic [WIDTH-1:0] a_fibo_series, b_fibo_series;
  logic [CNT_W-1:0] a_term_idx, b_term_idx;
  logic             a_overflow, b_overflow;
  logic             a_busy, b_busy;
  logic             a_done, b_done;

  int n_tests = 0;
  int n_fail  = 0;
  bit pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  fibo_gen_param #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SEED0(0), .SEED1(1)) u_dut_a (
    .clk(clk), .reset(rst_n), .start(start), .n_terms(n_terms),
    .out_ready(out_ready), .out_valid(a_out_valid), .fibo_series(a_fibo_series),
    .term_idx(a_term_idx), .overflow(a_overflow), .busy(a_busy), .done(a_done)
  );

  fibo_gen_param #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SEED0(5), .SEED1(7)) u_dut_b (
    .clk(clk), .reset(rst_n), .start(start), .n_terms(n_terms),
    .out_ready(out_ready), .out_valid(b_out_valid), .fibo_series(b_fibo_series),
    .term_idx(b_term_idx), .overflow(b_overflow), .busy(b_busy), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sequence model. Each term is the sum of the two before it. A term is
  // tagged when that sum does not fit in WIDTH bits, or when either input
  // term was already tagged. The overflow flag reports any tag seen so far.
  function automatic term_t model_term(input int s0, input int s1, input int idx);
    int    t [64];
    bit    w [64];
    term_t r;
    t[0] = s0 % MOD;
    t[1] = s1 % MOD;
    w[0] = 1'b0;
    w[1] = 1'b0;
    for (int i = 2; i <= idx; i++) begin
      int s;
      s    = t[i-1] + t[i-2];
      w[i] = (s >= MOD) || w[i-1] || w[i-2];
`ifdef FIBO_SAT_EN
      t[i] = w[i] ? (MOD - 1) : s;
`else
      t[i] = s % MOD;
`endif
    end
    r.val = 32'(t[idx]);
    r.ovf = 1'b0;
    for (int i = 0; i <= idx; i++) r.ovf = r.ovf | w[i];
    return r;
  endfunction

  function automatic logic pick_ready(input int mode, input int beat);
    case (mode)
      0:       return 1'b1;
      1:       return 1'($urandom_range(0, 1));
      default: return pat[beat % 8];
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid_a"}, 32'(a_out_valid), 0);
    check({tag, "_series_a"}, 32'(a_fibo_series), 0);
    check({tag, "_idx_a"}, 32'(a_term_idx), 0);
    check({tag, "_ovf_a"}, 32'(a_overflow), 0);
    check({tag, "_busy_a"}, 32'(a_busy), 0);
    check({tag, "_done_a"}, 32'(a_done), 0);
    check({tag, "_series_b"}, 32'(b_fibo_series), 5);
    check({tag, "_valid_b"}, 32'(b_out_valid), 0);
    check({tag, "_done_b"}, 32'(b_done), 0);
  endtask

  // Single run. mode selects the out_ready pattern: 0 = always ready,
  // 1 = random, 2 = fixed pattern. hold_start keeps start high while the run
  // is in progress. If abort_at >= 0, reset is pulsed while that term index
  // is presented.
  task automatic run_seq(input int n, input int mode, input bit hold_start, input int abort_at);
    int    idx;
    int    cyc;
    int    beat;
    term_t ea;
    term_t eb;
    @(negedge clk);
    start     = 1'b1;
    n_terms   = CNT_W'(n);
    out_ready = 1'b0;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    check("prime_valid_a", 32'(a_out_valid), 0);
    check("prime_valid_b", 32'(b_out_valid), 0);
    check("prime_busy_a", 32'(a_busy), 32'(n != 0));
    check("prime_ovf_a", 32'(a_overflow), 0);
    check("prime_done_a", 32'(a_done), 0);
    if (n == 0) begin
      @(posedge clk); #1;
      check("zero_done_a", 32'(a_done), 1);
      check("zero_done_b", 32'(b_done), 1);
      check("zero_valid_a", 32'(a_out_valid), 0);
      check("zero_busy_a", 32'(a_busy), 0);
      @(posedge clk); #1;
      check("zero_done_clr_a", 32'(a_done), 0);
      return;
    end
    out_ready = pick_ready(mode, 0);
    @(posedge clk); #1;
    idx  = 0;
    cyc  = 0;
    beat = 0;
    while (idx < n) begin
      if (cyc > 40 * n + 100) begin
        check("timeout", 0, 1);
        return;
      end
      ea = model_term(0, 1, idx);
      eb = model_term(5, 7, idx);
      check("valid_a", 32'(a_out_valid), 1);
      check("series_a", 32'(a_fibo_series), ea.val);
      check("idx_a", 32'(a_term_idx), 32'(idx));
      check("ovf_a", 32'(a_overflow), 32'(ea.ovf));
      check("busy_a", 32'(a_busy), 1);
      check("done_a", 32'(a_done), 0);
      check("valid_b", 32'(b_out_valid), 1);
      check("series_b", 32'(b_fibo_series), eb.val);
      check("idx_b", 32'(b_term_idx), 32'(idx));
      check("ovf_b", 32'(b_overflow), 32'(eb.ovf));
      if (abort_at == idx) begin
        rst_n = 1'b0;
        #1;
        check_reset_vals("abort");
        start     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check_reset_vals("abort_hold");
        rst_n = 1'b1;
        return;
      end
      out_ready = pick_ready(mode, beat);
      beat++;
      if (out_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    ea = model_term(0, 1, n - 1);
    eb = model_term(5, 7, n - 1);
    check("end_done_a", 32'(a_done), 1);
    check("end_valid_a", 32'(a_out_valid), 0);
    check("end_busy_a", 32'(a_busy), 0);
    check("end_series_a", 32'(a_fibo_series), ea.val);
    check("end_ovf_a", 32'(a_overflow), 32'(ea.ovf));
    check("end_done_b", 32'(b_done), 1);
    check("end_series_b", 32'(b_fibo_series), eb.val);
    check("end_ovf_b", 32'(b_overflow), 32'(eb.ovf));
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("end_done_clr_a", 32'(a_done), 0);
    check("end_done_clr_b", 32'(b_done), 0);
    check("end_ovf_keep_a", 32'(a_overflow), 32'(ea.ovf));
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    n_terms   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("post_reset");

    run_seq(10, 0, 1'b0, -1);
    run_seq(5, 2, 1'b0, -1);
    run_seq(16, 0, 1'b0, -1);
    run_seq(16, 1, 1'b0, -1);
    run_seq(0, 0, 1'b0, -1);
    run_seq(4, 0, 1'b0, -1);
    run_seq((1 << CNT_W) - 1, 1, 1'b0, -1);
    for (int r = 0; r < 6; r++) begin
      run_seq(int'($urandom_range(0, 40)), 1, 1'b0, -1);
    end
    run_seq(20, 0, 1'b1, 6);
    run_seq(14, 1, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
